// File: rtl/tc_program_loader8_4.sv
// Run-time program loader: zero-fills program memory, loads a byte stream into it,
// and serves the core's four-byte instruction fetch from the same memory.
module tc_program_loader8_4 #(
  parameter int    MAX_WORD_COUNT = 256,
  parameter int    UUID           = 0,
  parameter string NAME           = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic [7:0] address,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] byte_count
);

  localparam int         AW       = (MAX_WORD_COUNT > 1) ? $clog2(MAX_WORD_COUNT) : 1;
  localparam logic [7:0] LAST_IDX = 8'(MAX_WORD_COUNT - 1);
  localparam logic [8:0] DEPTH    = 9'(MAX_WORD_COUNT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] ptr_reg, ptr_next;
  logic [8:0] count_reg, count_next;
  logic       mem_we;
  logic [7:0] mem_wdata;

  logic [7:0] mem [MAX_WORD_COUNT];

  // Identification parameters only tag the instance.
  logic unused_params;
  assign unused_params = (UUID != 0) || (NAME != "");

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 8'd0;
      count_reg <= 9'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  // One pointer serves both the clear sweep and the load write position.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    mem_we     = 1'b0;
    mem_wdata  = 8'd0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_next = ST_CLEAR;
          ptr_next   = 8'd0;
          count_next = 9'd0;
        end
      end
      ST_CLEAR: begin
        mem_we   = 1'b1;
        ptr_next = ptr_reg + 8'd1;
        if (ptr_reg == LAST_IDX) begin
          state_next = ST_LOAD;
          ptr_next   = 8'd0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          mem_we     = 1'b1;
          mem_wdata  = in_data;
          ptr_next   = ptr_reg + 8'd1;
          count_next = count_reg + 9'd1;
          if (in_last) begin
            state_next = ST_DONE;
          end else if (count_reg + 9'd1 == DEPTH) begin
            state_next = ST_ERR;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[ptr_reg[AW-1:0]] <= mem_wdata;
    end
  end

  assign in_ready   = (state_reg == ST_LOAD);
  assign busy       = (state_reg == ST_CLEAR) || (state_reg == ST_LOAD);
  assign done       = (state_reg == ST_DONE);
  assign error      = (state_reg == ST_ERR);
  assign byte_count = count_reg;

  // Fetch ports read the pre-edge memory contents; indices past the depth read as 0.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fetch
    logic [7:0] idx;
    logic [7:0] byte_reg;

    assign idx = address + 8'(gi);

    always_ff @(posedge clk) begin
      if (rst || busy) begin
        byte_reg <= 8'd0;
      end else if ({1'b0, idx} < DEPTH) begin
        byte_reg <= mem[idx[AW-1:0]];
      end else begin
        byte_reg <= 8'd0;
      end
    end
  end

  assign out0 = g_fetch[0].byte_reg;
  assign out1 = g_fetch[1].byte_reg;
  assign out2 = g_fetch[2].byte_reg;
  assign out3 = g_fetch[3].byte_reg;

endmodule

// File: tb/tb_tc_program_loader8_4.sv
// Directed bench for tc_program_loader8_4: a 256-byte instance for load/fetch/reload/reset
// scenarios and a 16-byte instance for the overflow case.
module tb_tc_program_loader8_4;

  logic       clk;
  logic       rst;

  logic       start, in_valid, in_last, in_ready;
  logic [7:0] in_data, address;
  logic [7:0] out0, out1, out2, out3;
  logic       busy, done, error;
  logic [8:0] byte_count;

  logic       s_start, s_valid, s_last, s_ready;
  logic [7:0] s_data, s_address;
  logic [7:0] s_out0, s_out1, s_out2, s_out3;
  logic       s_busy, s_done, s_error;
  logic [8:0] s_count;

  int checks;
  int errors;

  logic [7:0] img [12];

  tc_program_loader8_4 #(.MAX_WORD_COUNT(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .address(address),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .busy(busy), .done(done), .error(error), .byte_count(byte_count)
  );

  tc_program_loader8_4 #(.MAX_WORD_COUNT(16)) dut16 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_data(s_data),
    .in_last(s_last), .in_ready(s_ready), .address(s_address),
    .out0(s_out0), .out1(s_out1), .out2(s_out2), .out3(s_out3),
    .busy(s_busy), .done(s_done), .error(s_error), .byte_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts cycles after the start edge until in_ready; flags any sample that is not busy with zero fetch.
  task automatic wait_ready(output int cyc, output int bad);
    cyc = 0;
    bad = 0;
    do begin
      tick();
      cyc++;
      if (busy !== 1'b1 || {out0, out1, out2, out3} !== 32'h0) bad++;
    end while (in_ready !== 1'b1 && cyc < 400);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a, input string tag, input logic [31:0] exp);
    address = a;
    tick();
    check_val(tag, {out0, out1, out2, out3}, exp);
  endtask

  initial begin
    int cyc;
    int bad;
    checks = 0;
    errors = 0;
    img[0] = 8'h5A; img[1] = 8'hA5; img[2]  = 8'h3C; img[3]  = 8'hC3;
    img[4] = 8'h0F; img[5] = 8'hF0; img[6]  = 8'h69; img[7]  = 8'h96;
    img[8] = 8'h12; img[9] = 8'h34; img[10] = 8'h56; img[11] = 8'h78;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; address = 8'h00;
    s_start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_address = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check_val("reset_flags", {28'h0, in_ready, busy, done, error}, 32'h0);
    check_val("reset_count", {23'h0, byte_count}, 32'h0);
    check_val("reset_out", {out0, out1, out2, out3}, 32'h0);

    // Overflow on the 16-byte instance.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    cyc = 0;
    while (s_ready !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check_val("ovf_clear_len", cyc, 16);
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h30 + 8'(i);
      tick();
      if (i == 14) check_val("ovf_slot15_ok", {30'h0, s_error, s_ready}, 32'h1);
    end
    check_val("ovf_flags", {29'h0, s_error, s_ready, s_done}, 32'h4);
    check_val("ovf_count", {23'h0, s_count}, 32'd16);
    s_data = 8'h99;
    tick();
    tick();
    check_val("ovf_17th_held", {22'h0, s_error, s_count}, {22'h0, 1'b1, 9'd16});
    s_valid = 1'b0;
    s_address = 8'h0E;
    tick();
    check_val("ovf_fetch_edge", {s_out0, s_out1, s_out2, s_out3}, 32'h3E3F0000);

    // Basic load.
    pulse_start();
    check_val("t1_busy_after_start", {31'h0, busy}, 32'h1);
    wait_ready(cyc, bad);
    check_val("t1_clear_len", cyc, 256);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b1);
    check_val("t1_done", {29'h0, done, error, busy}, 32'h4);
    check_val("t1_count", {23'h0, byte_count}, 32'd5);
    fetch(8'h00, "t1_fetch0", 32'h11223344);
    fetch(8'h02, "t1_fetch2", 32'h33445500);
    send_byte(8'hEE, 1'b0);
    check_val("t1_idle_valid_count", {23'h0, byte_count}, 32'd5);
    fetch(8'h04, "t1_idle_valid_nowrite", 32'h55000000);

    // Full 256-byte image, last on the final slot.
    pulse_start();
    wait_ready(cyc, bad);
    check_val("t2_clear_len", cyc, 256);
    for (int i = 0; i < 256; i++) send_byte(8'(i), i == 255);
    check_val("t2_flags", {30'h0, done, error}, 32'h2);
    check_val("t2_count", {23'h0, byte_count}, 32'd256);
    fetch(8'hFE, "t2_fetch_wrap", 32'hFEFF0001);
    fetch(8'h80, "t2_fetch_mid", 32'h80818283);

    // Gapped stream.
    pulse_start();
    wait_ready(cyc, bad);
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(img[i], i == 11);
    end
    check_val("t4_count", {23'h0, byte_count}, 32'd12);
    fetch(8'h00, "t4_fetch0", {img[0], img[1], img[2], img[3]});
    fetch(8'h04, "t4_fetch4", {img[4], img[5], img[6], img[7]});
    fetch(8'h08, "t4_fetch8", {img[8], img[9], img[10], img[11]});
    fetch(8'h0C, "t4_fetch_cleared", 32'h0);

    // Reload after DONE; fetch at 4 would show stale 0xAA if not gated during CLEAR.
    pulse_start();
    wait_ready(cyc, bad);
    for (int i = 0; i < 8; i++) send_byte(8'hAA, i == 7);
    fetch(8'h04, "t5_first_image", 32'hAAAAAAAA);
    pulse_start();
    wait_ready(cyc, bad);
    check_val("t5_clear_len", cyc, 256);
    check_val("t5_clear_busy_zero", bad, 0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    fetch(8'h00, "t5_reload_fetch", 32'h01020000);

    // Reset mid-load, with a simultaneous start that must lose.
    pulse_start();
    wait_ready(cyc, bad);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h99, 1'b0);
    check_val("t6_count_before", {23'h0, byte_count}, 32'd3);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check_val("t6_flags", {28'h0, in_ready, busy, done, error}, 32'h0);
    check_val("t6_count", {23'h0, byte_count}, 32'h0);
    check_val("t6_out", {out0, out1, out2, out3}, 32'h0);
    tick();
    check_val("t6_still_idle", {31'h0, busy}, 32'h0);
    pulse_start();
    wait_ready(cyc, bad);
    check_val("t6_restart_clear_len", cyc, 256);
    send_byte(8'h42, 1'b1);
    check_val("t6_restart_done", {22'h0, done, byte_count}, {22'h0, 1'b1, 9'd1});
    fetch(8'h00, "t6_restart_fetch", 32'h42000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tc_program_loader8_4.md
# tc_program_loader8_4

Byte-stream writer for the 8-bit program memory. It accepts a program image over a valid/ready byte stream and zero-fills the memory before loading. It then serves the same four-byte instruction fetch the core uses (out0..out3 = bytes at address..address+3). It sits between the host/test loader interface and the CPU fetch stage, so program images can be loaded at run time instead of from a file at elaboration.

## Interface
- MAX_WORD_COUNT, 256, memory depth in bytes; legal range 4..256.
- UUID, 0, instance identifier; no functional effect.
- NAME, "", instance name; no functional effect.

- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle pulse that begins clear+load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  stream byte present.
- in_data  input  8  stream byte.
- in_last  input  1  marks final byte of the image; qualified by in_valid.
- in_ready  output  1  block accepts a byte this cycle.
- address  input  8  fetch address.
- out0..out3  output  8 each  registered fetch bytes at address+0..+3.
- busy  output  1  high in CLEAR and LOAD.
- done  output  1  high in DONE.
- error  output  1  high in ERR.
- byte_count  output  9  bytes accepted since the last start.

## Operation
- A transfer happens on a clock edge where in_valid && in_ready.
- States: IDLE, CLEAR, LOAD, DONE, ERR.
- IDLE: start -> CLEAR. On entry to CLEAR, the clear pointer and byte_count are set to 0.
- CLEAR: writes 0 to mem[ptr] and increments ptr each cycle. After writing mem[MAX_WORD_COUNT-1], goes to LOAD with write pointer 0. in_ready=0.
- LOAD: in_ready=1. Each transfer writes mem[wp]=in_data, then wp++ and byte_count++.
  - Transfer with in_last=1 -> DONE.
  - Transfer with in_last=0 that makes byte_count==MAX_WORD_COUNT -> ERR (overflow).
  - A transfer with in_last=1 on the final slot is legal and goes to DONE.
- DONE/ERR: in_ready=0; memory and byte_count hold. start -> CLEAR (restart).
- start is ignored in CLEAR and LOAD.
- Fetch:
  - Index for out_k is (address+k) mod 256, 8-bit wrap.
  - An index >= MAX_WORD_COUNT reads as 0.
  - While busy or rst, the registered outputs load 0.
- Memory contents are not affected by rst. After reset and before the first load, reads return uninitialised data; the bench must not check these.

## Timing
- Reset values: state IDLE, out0..out3=0, in_ready=0, busy=0, done=0, error=0, byte_count=0, pointers=0.
- Fetch latency: 1 cycle. The outputs after edge N reflect address and memory as sampled before edge N (read-before-write).
- in_ready, busy, done and error are decoded directly from the state register, with no combinational path from inputs.
- Load latency: start at edge N, CLEAR occupies edges N+1..N+MAX_WORD_COUNT, and in_ready rises after edge N+MAX_WORD_COUNT.
- The final transfer at edge M: done=1 after edge M, and the fetch outputs are valid from edge M+1.
- Overflow: the offending transfer is written. error=1 after that edge and further bytes are not accepted.
- rst mid-CLEAR or mid-LOAD: returns to IDLE next edge. Memory keeps a partial image; byte_count=0.
- Simultaneous rst and start: rst wins.
- in_valid outside LOAD: ignored, no write.

## Test plan
1. Reset then load: start, stream 0x11,0x22,0x33,0x44,0x55 (last on 0x55) -> byte_count=5, done=1. Then address=0x00 -> next cycle out=11,22,33,44; address=0x02 -> 33,44,55,00 (00 from the zero-fill).
2. Wrap: MAX=256, load 256 bytes with value=index, last on byte 255 -> done=1, error=0. Then address=0xFE -> FE,FF,00,01.
3. Overflow: MAX=16, stream 17 bytes, none with last -> error=1 after the 16th transfer, byte_count=16, in_ready=0, and the 17th byte stays pending on the bus.
4. Backpressure/gaps: toggle in_valid randomly during LOAD -> only valid cycles are written, and the contents match the image in order.
5. Reload after DONE: load 8 bytes of 0xAA, then start and load 2 bytes 0x01,0x02 -> address=0 reads 01,02,00,00 (previous data cleared). Check CLEAR lasts exactly MAX_WORD_COUNT cycles with busy=1 and out0..out3=0 throughout.
6. Reset mid-LOAD: after 3 bytes assert rst for 1 cycle -> state IDLE, outputs 0, byte_count=0. start while rst is high is ignored, and the next start restarts cleanly.
